// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared constants, clog2 and the Q = X*T + N result function.
// Optional feature macro: Q_SAT_EN (saturate instead of wrap on overflow).
package q_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned W_MAX     = 64;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Operands arrive zero-extended to W_MAX; w is the live operand width.
  // The wrap build only needs the sum modulo 2^W_MAX, which already holds the low w bits.
`ifdef Q_SAT_EN
  localparam int unsigned SUM_W = 2 * W_MAX + 1;
`else
  localparam int unsigned SUM_W = W_MAX;
`endif

  function automatic logic [W_MAX-1:0] q_f(input logic [W_MAX-1:0] x,
                                           input logic [W_MAX-1:0] t,
                                           input logic [W_MAX-1:0] n,
                                           input int unsigned      w);
    logic [SUM_W-1:0] sum;
    logic [W_MAX-1:0] mask;
    logic [W_MAX-1:0] res;
    sum  = SUM_W'(x) * SUM_W'(t) + SUM_W'(n);
    mask = (w >= W_MAX) ? '1 : ((W_MAX'(1) << w) - W_MAX'(1));
    res  = sum[W_MAX-1:0] & mask;
`ifdef Q_SAT_EN
    if ((sum >> w) != '0) res = mask;
`endif
    return res;
  endfunction

endpackage

// File: rtl/q_sync_fifo.sv
// rtl/q_sync_fifo.sv - DEPTH-entry operand FIFO with wrap-bit pointers.
// A push is refused while full, even when a pop happens on the same edge.
module q_sync_fifo
  import q_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/q_mac_stream.sv
// rtl/q_mac_stream.sv - Q = X*T + N stream block: X/T FIFOs, sticky N, registered Q.
// Optional feature macro: Q_SAT_EN (saturating result, same handshake timing).
module q_mac_stream
  import q_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] N,
  input  logic         N_valid,
  output logic         N_ready,
  input  logic [W-1:0] X,
  input  logic         X_valid,
  output logic         X_ready,
  input  logic [W-1:0] T,
  input  logic         T_valid,
  output logic         T_ready,
  output logic [W-1:0] Q,
  output logic         Q_valid,
  input  logic         Q_ready
);

  logic         x_full, x_empty, t_full, t_empty;
  logic [W-1:0] x_head, t_head;
  logic [W-1:0] n_reg;
  logic         fire;

  // Readies depend only on reset and FIFO state, never on the matching valid.
  assign N_ready = aresetn;
  assign X_ready = aresetn && !x_full;
  assign T_ready = aresetn && !t_full;
  assign fire    = !x_empty && !t_empty && (!Q_valid || Q_ready);

  q_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_x_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (X_valid && X_ready),
    .din     (X),
    .full    (x_full),
    .pop     (fire),
    .dout    (x_head),
    .empty   (x_empty)
  );

  q_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_t_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (T_valid && T_ready),
    .din     (T),
    .full    (t_full),
    .pop     (fire),
    .dout    (t_head),
    .empty   (t_empty)
  );

  // A fire on the same edge as an N load still sees the old n_reg.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      n_reg   <= '0;
      Q       <= '0;
      Q_valid <= 1'b0;
    end else begin
      if (N_valid) n_reg <= N;
      if (fire) begin
        Q       <= W'(q_f(W_MAX'(x_head), W_MAX'(t_head), W_MAX'(n_reg), W));
        Q_valid <= 1'b1;
      end else if (Q_ready) begin
        Q_valid <= 1'b0;
      end
    end
  end

endmodule
